// File: rtl/axis_rotate_pkg.sv
// Shared tuser field layout and rotate-direction constants for axis_rotate / axis_unrotate.
// Also holds the state type of the output buffer used by axis_unrotate.
package axis_rotate_pkg;

    localparam int unsigned SHIFT_LSB = 0;
    localparam logic        DIR_LEFT  = 1'b0;
    localparam logic        DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_BUSY,
        SKID_FULL
    } skid_state_t;

    function automatic int unsigned shift_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int unsigned dir_bit(input int unsigned data_width);
        return SHIFT_LSB + shift_bits(data_width);
    endfunction

    // Source byte feeding output byte dst when undoing an upstream rotation of n bytes.
    function automatic int unsigned src_byte(input int unsigned dst, input int unsigned n,
                                             input int unsigned bytes, input logic dir);
        int unsigned m;
        m = n % bytes;
        if (dir == DIR_RIGHT)
            return (dst + bytes - m) % bytes;
        return (dst + m) % bytes;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// One-cycle registered AXI-Stream stage carrying an opaque payload.
// AXIS_UNROTATE_SKID_EN selects a 2-entry skid buffer with registered s_ready.
module axis_skid_buffer
    import axis_rotate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    skid_state_t      state;
    skid_state_t      state_next;
    logic [WIDTH-1:0] out_q;
    logic             load_out;

    always_ff @(posedge aclk) begin
        if (areset)
            state <= SKID_EMPTY;
        else
            state <= state_next;
    end

`ifdef AXIS_UNROTATE_SKID_EN
    logic [WIDTH-1:0] skid_q;
    logic             load_skid;
    logic             out_from_skid;

    // s_ready depends only on state, so FULL is entered rather than back-pressuring.
    always_comb begin
        state_next    = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        unique case (state)
            SKID_EMPTY: begin
                if (s_valid) begin
                    state_next = SKID_BUSY;
                    load_out   = 1'b1;
                end
            end
            SKID_BUSY: begin
                if (s_valid && !m_ready) begin
                    state_next = SKID_FULL;
                    load_skid  = 1'b1;
                end else if (s_valid) begin
                    load_out = 1'b1;
                end else if (m_ready) begin
                    state_next = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (m_ready) begin
                    state_next    = SKID_BUSY;
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: state_next = SKID_EMPTY;
        endcase
    end

    always_comb begin
        s_ready = !areset && (state != SKID_FULL);
        m_valid = !areset && (state != SKID_EMPTY);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_skid)
                skid_q <= s_data;
            if (load_out)
                out_q <= out_from_skid ? skid_q : s_data;
        end
    end
`else
    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (s_valid) begin
                    state_next = SKID_BUSY;
                    load_out   = 1'b1;
                end
            end
            SKID_BUSY: begin
                if (m_ready) begin
                    if (s_valid)
                        load_out = 1'b1;
                    else
                        state_next = SKID_EMPTY;
                end
            end
            default: state_next = SKID_EMPTY;
        endcase
    end

    always_comb begin
        m_valid = !areset && (state == SKID_BUSY);
        s_ready = !areset && ((state != SKID_BUSY) || m_ready);
    end

    always_ff @(posedge aclk) begin
        if (areset)
            out_q <= '0;
        else if (load_out)
            out_q <= s_data;
    end
`endif

    always_comb begin
        m_data = areset ? '0 : out_q;
    end

endmodule

// File: rtl/axis_unrotate.sv
// Undoes the byte rotation applied by axis_rotate, using the rotate command carried in tuser.
// Build option: AXIS_UNROTATE_SKID_EN selects the 2-entry skid output buffer.
module axis_unrotate
    import axis_rotate_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 64
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep
);

    localparam int unsigned BYTES      = DATA_WIDTH / 8;
    localparam int unsigned SHIFT_BITS = shift_bits(DATA_WIDTH);
    localparam int unsigned DIR_BIT    = dir_bit(DATA_WIDTH);
    localparam int unsigned PAYLOAD_W  = USER_WIDTH + 1 + BYTES + DATA_WIDTH;

    logic [SHIFT_BITS-1:0] shift_n;
    logic                  dir;
    logic [DATA_WIDTH-1:0] rot_data;
    logic [BYTES-1:0]      rot_keep;
    logic [PAYLOAD_W-1:0]  s_payload;
    logic [PAYLOAD_W-1:0]  m_payload;

    assign shift_n = s_axis_tuser[SHIFT_LSB +: SHIFT_BITS];
    assign dir     = s_axis_tuser[DIR_BIT];

    // keep bit i travels with data byte i
    always_comb begin
        rot_data = '0;
        rot_keep = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            rot_data[8*i +: 8] = s_axis_tdata[8*src_byte(i, 32'(shift_n), BYTES, dir) +: 8];
            rot_keep[i]        = s_axis_tkeep[src_byte(i, 32'(shift_n), BYTES, dir)];
        end
    end

    assign s_payload = {s_axis_tuser, s_axis_tlast, rot_keep, rot_data};

    axis_skid_buffer #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .aclk    (aclk),
        .areset  (areset),
        .s_data  (s_payload),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .m_data  (m_payload),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = m_payload;

endmodule

// File: tb/tb_axis_unrotate.sv
// Self-checking bench for axis_unrotate: directed literal vectors plus a queue-based
// reference model checked on every output transfer.
module tb_axis_unrotate;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [63:0] s_tdata = '0;
    logic [63:0] s_tuser = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [7:0]  s_tkeep = '0;
    logic [63:0] m_tdata;
    logic [63:0] m_tuser;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [7:0]  m_tkeep;

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    int last_cnt = 0;
    bit rand_ready = 1'b0;
    bit stall_pending = 1'b0;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [63:0] user;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t held;
    beat_t exp_b;

    axis_unrotate #(
        .DATA_WIDTH (64),
        .USER_WIDTH (64)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tkeep  (s_tkeep),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tkeep  (m_tkeep)
    );

    always #5 aclk = ~aclk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: DIR=0 means upstream rotated left, so rotate right; DIR=1 the reverse.
    function automatic beat_t model(input logic [63:0] d, input logic [7:0] k,
                                    input logic [63:0] u, input logic l);
        beat_t        r;
        int unsigned  n;
        logic [127:0] dd;
        logic [15:0]  kk;
        n  = 32'(u[2:0]);
        r.user = u;
        r.last = l;
        if (!u[3]) begin
            dd = {d, d} >> (8 * n);
            kk = {k, k} >> n;
            r.data = dd[63:0];
            r.keep = kk[7:0];
        end else begin
            dd = {d, d} << (8 * n);
            kk = {k, k} << n;
            r.data = dd[127:64];
            r.keep = kk[15:8];
        end
        return r;
    endfunction

    always @(negedge aclk) begin
        if (areset) begin
            check64("rst_m_tvalid", 64'(m_tvalid), 64'd0);
            check64("rst_s_tready", 64'(s_tready), 64'd0);
            check64("rst_m_tdata", m_tdata, 64'd0);
            check64("rst_m_tuser", m_tuser, 64'd0);
            check64("rst_m_tkeep", 64'(m_tkeep), 64'd0);
            check64("rst_m_tlast", 64'(m_tlast), 64'd0);
            exp_q.delete();
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                check64("stall_valid", 64'(m_tvalid), 64'd1);
                check64("stall_data", m_tdata, held.data);
                check64("stall_keep", 64'(m_tkeep), 64'(held.keep));
                check64("stall_user", m_tuser, held.user);
                check64("stall_last", 64'(m_tlast), 64'(held.last));
            end
            if (m_tvalid && m_tready) begin
                out_cnt++;
                if (m_tlast)
                    last_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", m_tdata);
                end else begin
                    exp_b = exp_q.pop_front();
                    check64("out_data", m_tdata, exp_b.data);
                    check64("out_keep", 64'(m_tkeep), 64'(exp_b.keep));
                    check64("out_user", m_tuser, exp_b.user);
                    check64("out_last", 64'(m_tlast), 64'(exp_b.last));
                end
            end
            stall_pending = m_tvalid && !m_tready;
            held = '{data: m_tdata, keep: m_tkeep, user: m_tuser, last: m_tlast};
            if (s_tvalid && s_tready)
                exp_q.push_back(model(s_tdata, s_tkeep, s_tuser, s_tlast));
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rand_ready)
                m_tready = 1'($urandom_range(0, 1));
        end
    end

    // Single beat into an idle DUT with m_tready high; output checked against literals.
    task automatic directed(input string name, input logic [63:0] d, input logic [7:0] k,
                            input logic [63:0] u, input logic l,
                            input logic [63:0] exp_d, input logic [7:0] exp_k);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tuser  = u;
        s_tlast  = l;
        check64({name, "_ready"}, 64'(s_tready), 64'd1);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check64({name, "_valid"}, 64'(m_tvalid), 64'd1);
        check64({name, "_data"}, m_tdata, exp_d);
        check64({name, "_keep"}, 64'(m_tkeep), 64'(exp_k));
        check64({name, "_user"}, m_tuser, u);
        check64({name, "_last"}, 64'(m_tlast), 64'(l));
    endtask

    // Call at a rising edge; returns at the rising edge that accepted the beat.
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic [63:0] u,
                        input logic l);
        bit ok;
        ok = 1'b0;
        #1;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tuser  = u;
        s_tlast  = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge aclk);
            ok = s_tready;
            @(posedge aclk);
            if (ok)
                break;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
    endtask

    initial begin
        int base;
        int base_last;
        int acc;
        int waited;

        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        #1;
        check64("ready_after_reset", 64'(s_tready), 64'd1);
        check64("valid_after_reset", 64'(m_tvalid), 64'd0);

        m_tready = 1'b1;
        directed("left1", 64'h0203040506070801, 8'h02, 64'd1, 1'b0,
                 64'h0102030405060708, 8'h01);
        directed("right1", 64'h0801020304050607, 8'h80, 64'd9, 1'b0,
                 64'h0102030405060708, 8'h01);
        directed("left2", 64'h0304050607080102, 8'h0F, 64'd2, 1'b1,
                 64'h0102030405060708, 8'hC3);
        directed("right2", 64'h0708010203040506, 8'h0F, 64'd10, 1'b0,
                 64'h0102030405060708, 8'h3C);
        directed("pass_l", 64'h1122334455667788, 8'hA5, 64'd0, 1'b0,
                 64'h1122334455667788, 8'hA5);
        directed("pass_r", 64'h1122334455667788, 8'h5A, 64'd8, 1'b1,
                 64'h1122334455667788, 8'h5A);
        directed("right7", 64'h0203040506070801, 8'h02, 64'd15, 1'b0,
                 64'h0102030405060708, 8'h01);
        directed("hi_user", 64'h0203040506070801, 8'h02, 64'hFFFF_0000_0000_0011, 1'b0,
                 64'h0102030405060708, 8'h01);

        // back-to-back beats with m_tready held high
        @(posedge aclk);
        base = out_cnt;
        acc  = 0;
        for (int i = 0; i < 12; i++) begin
            if (i != 0)
                @(posedge aclk);
            #1;
            s_tvalid = 1'b1;
            s_tdata  = {$urandom, $urandom};
            s_tkeep  = 8'($urandom);
            s_tuser  = 64'($urandom_range(0, 15));
            s_tlast  = (i == 11);
            @(negedge aclk);
            if (s_tready)
                acc++;
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge aclk);
        #1;
        check64("thru_accepts", 64'(acc), 64'd12);
        check64("thru_outputs", 64'(out_cnt - base), 64'd12);

        // 16-beat packet against random back-pressure
        base      = out_cnt;
        base_last = last_cnt;
        rand_ready = 1'b1;
        @(posedge aclk);
        for (int i = 0; i < 16; i++)
            send({$urandom, $urandom}, 8'($urandom), {32'($urandom), 28'd0, 4'($urandom)},
                 (i == 15));
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge aclk);
            waited++;
        end
        check64("pkt_drained", 64'(exp_q.size()), 64'd0);
        check64("pkt_outputs", 64'(out_cnt - base), 64'd16);
        check64("pkt_tlast_count", 64'(last_cnt - base_last), 64'd1);
        rand_ready = 1'b0;

        // reset pulse while beats are held
        @(posedge aclk);
        #1;
        m_tready = 1'b0;
        @(posedge aclk);
        send(64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 64'd3, 1'b0);
        #1;
        s_tvalid = 1'b1;
        s_tdata  = 64'h1111_2222_3333_4444;
        s_tuser  = 64'd12;
        @(posedge aclk);
        @(posedge aclk);
        #1;
        check64("held_valid", 64'(m_tvalid), 64'd1);
        areset   = 1'b1;
        s_tvalid = 1'b0;
        #1;
        check64("pulse_s_tready", 64'(s_tready), 64'd0);
        check64("pulse_m_tvalid", 64'(m_tvalid), 64'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        #1;
        check64("pulse_ready_next", 64'(s_tready), 64'd1);
        check64("pulse_valid_next", 64'(m_tvalid), 64'd0);
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge aclk);
            #2;
            check64("no_stale_beat", 64'(m_tvalid), 64'd0);
        end

        directed("post_rst", 64'h0801020304050607, 8'h80, 64'd9, 1'b1,
                 64'h0102030405060708, 8'h01);
        @(posedge aclk);
        @(posedge aclk);
        #1;
        check64("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_unrotate.md
AXIS_UNROTATE -- requirements
Module: axis_unrotate

Interface
REQ-001 The block SHALL have a parameter DATA_WIDTH, default 64, giving the tdata width in bits (multiple of 8, at least 16).
REQ-002 The block SHALL have a parameter USER_WIDTH, default 64, giving the tuser width in bits (at least SHIFT_BITS+1).
REQ-003 Port aclk  input  1  clock; all logic SHALL be rising-edge aclk.
REQ-004 Port areset  input  1  synchronous active-high reset.
REQ-005 Port s_axis_tdata  input  DATA_WIDTH  rotated data beat.
REQ-006 Port s_axis_tuser  input  USER_WIDTH  rotate command applied upstream.
REQ-007 Port s_axis_tvalid / s_axis_tready  input / output  1 each  slave handshake.
REQ-008 Port s_axis_tlast  input  1  packet end.
REQ-009 Port s_axis_tkeep  input  DATA_WIDTH/8  byte qualifiers, rotated with the data.
REQ-010 Ports m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tkeep  mirror REQ-005..009 with reversed direction  restored beat.

Function
REQ-011 SHIFT_BITS SHALL equal clog2(DATA_WIDTH/8); tuser[SHIFT_BITS-1:0] = byte count N; tuser[SHIFT_BITS] = DIR (0 = upstream rotated left, 1 = upstream rotated right); higher tuser bits SHALL be ignored for the rotation.
REQ-012 With DIR=0 the output SHALL be the input rotated right by N bytes; with DIR=1 it SHALL be rotated left by N bytes, so that it inverts the upstream axis_rotate.
REQ-013 tkeep SHALL be rotated by the same amount and direction as tdata, bit i following byte i.
REQ-014 N=0 SHALL pass tdata and tkeep unchanged for either DIR.
REQ-015 tuser and tlast SHALL pass through unmodified, aligned with their beat.
REQ-016 A beat SHALL transfer only when tvalid and tready are both high on a rising edge; m_axis_tvalid SHALL NOT deassert, and m_axis payload SHALL NOT change, until the beat is accepted.
REQ-017 Latency SHALL be one cycle: a beat accepted on edge k SHALL appear on m_axis after edge k, with registered outputs.
REQ-018 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated.
REQ-019 When input accept and output accept occur on the same edge, the block SHALL load the new beat and retire the old one with no bubble.

Reset
REQ-020 While areset is high, m_axis_tvalid, s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tlast and m_axis_tkeep SHALL be 0.
REQ-021 s_axis_tready SHALL be 1 in the first cycle after areset falls.
REQ-022 Reset asserted mid-stream SHALL discard all held beats; no held beat SHALL appear after reset.

Configuration
REQ-023 With macro AXIS_UNROTATE_SKID_EN defined, the block SHALL use a 2-entry skid buffer: s_axis_tready is registered (no combinational path from m_axis_tready) and full throughput holds under any tready pattern.
REQ-024 Without AXIS_UNROTATE_SKID_EN, the block SHALL use a single output register with s_axis_tready = !m_axis_tvalid || m_axis_tready; latency and REQ-016..019 SHALL still hold.

Structure
REQ-025 Package axis_rotate_pkg SHALL hold the tuser field positions (shift field, DIR bit index) and the DIR_LEFT/DIR_RIGHT constants, shared with axis_rotate.
REQ-026 The skid buffer SHALL be a sub-module, axis_skid_buffer, parameterised on payload width; the rotation SHALL be combinational logic ahead of it.

Verification
REQ-027 tdata 64'h0203040506070801, tkeep 8'h02, tuser 1, m_tready 1 -> output 64'h0102030405060708, tkeep 8'h01, tuser 1, one cycle later.
REQ-028 tdata 64'h0801020304050607, tkeep 8'h80, tuser 9 -> output 64'h0102030405060708, tkeep 8'h01.
REQ-029 tuser 2 on 64'h0304050607080102 -> 64'h0102030405060708; tuser 10 on 64'h0708010203040506 -> same; tuser 0 and tuser 8 -> passthrough.
REQ-030 Stream of 16 beats with tlast on beat 16 and random m_tready -> all beats in order, payload stable while stalled, tlast on the 16th output only.
REQ-031 Continuous valid with m_tready held at 1 -> one beat per cycle after the first (both configurations).
REQ-032 areset pulsed for 1 cycle while 2 beats are held -> m_tvalid 0 and s_tready 0 during reset, s_tready 1 the next cycle, no stale beat output.
